// File: rtl/pb_pkg.sv
// Shared definitions for the pushbutton conditioner: channel FSM states,
// channel count, operand width and default timing constants.
package pb_pkg;

    localparam int NUM_CH              = 4;
    localparam int OPERAND_W           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 64;
    localparam int DEF_REPEAT_PERIOD   = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } pb_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold (max_count - 1); never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One pushbutton channel: two-flop synchronizer, debounce FSM with down-counter,
// and an auto-repeat timer compiled in only when PB_CONDITIONER_AUTOREPEAT_EN is defined.
module pb_debounce_ch
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CW      = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] DEB_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync;
    pb_state_t     state;
    pb_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          pulse_nxt;

`ifdef PB_CONDITIONER_AUTOREPEAT_EN
    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] rpt_cnt;
    logic [CW-1:0] rpt_cnt_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // Counters only decrement when non-zero, so they can never wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
`ifdef PB_CONDITIONER_AUTOREPEAT_EN
        rpt_cnt_nxt = rpt_cnt;
`endif
        case (state)
            IDLE: begin
                if (sync) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = DEB_LOAD;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = HELD;
                    pulse_nxt = 1'b1;
`ifdef PB_CONDITIONER_AUTOREPEAT_EN
                    rpt_cnt_nxt = DELAY_LOAD;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = DEB_LOAD;
                end
`ifdef PB_CONDITIONER_AUTOREPEAT_EN
                else if (rpt_cnt == '0) begin
                    pulse_nxt   = 1'b1;
                    rpt_cnt_nxt = PERIOD_LOAD;
                end else begin
                    rpt_cnt_nxt = rpt_cnt - 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_nxt = HELD;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
        end
    end

`ifdef PB_CONDITIONER_AUTOREPEAT_EN
    // The repeat timer is left untouched outside HELD, so a bounce through
    // RELEASE_WAIT freezes it and a return to HELD resumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt_nxt;
        end
    end
`endif

    assign level = (state == HELD) || (state == RELEASE_WAIT);

endmodule

// File: rtl/pb_conditioner.sv
// Four-button conditioner feeding the adder: per-channel debounce plus an operand
// pipeline aligned to the press strobes. Auto-repeat via PB_CONDITIONER_AUTOREPEAT_EN.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    pb_raw,
    input  logic [OPERAND_W-1:0] a_raw,
    output logic [NUM_CH-1:0]    pb_level,
    output logic [NUM_CH-1:0]    pb_pulse,
    output logic [OPERAND_W-1:0] a_out
);

    // The first two stages synchronize a_raw; the rest delay it so a_out shows
    // the value sampled DEBOUNCE_CYCLES edges before the strobe.
    localparam int A_DEPTH = DEBOUNCE_CYCLES + 1;

    logic [OPERAND_W-1:0] a_pipe [A_DEPTH];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pb_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (pb_raw[ch]),
            .level (pb_level[ch]),
            .pulse (pb_pulse[ch])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < A_DEPTH; i++) begin
                a_pipe[i] <= '0;
            end
        end else begin
            a_pipe[0] <= a_raw;
            for (int i = 1; i < A_DEPTH; i++) begin
                a_pipe[i] <= a_pipe[i-1];
            end
        end
    end

    assign a_out = a_pipe[A_DEPTH-1];

endmodule

// File: tb/tb_pb_conditioner.sv
// Scoreboard bench for pb_conditioner with DEBOUNCE_CYCLES=4; define
// PB_CONDITIONER_AUTOREPEAT_EN to also expect the auto-repeat pulses.
module tb_pb_conditioner;

    localparam int DEB = 4;

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
        logic [3:0] a;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic [3:0] pb_raw = 4'h0;
    logic [3:0] a_raw  = 4'h0;
    logic [3:0] pb_level;
    logic [3:0] pb_pulse;
    logic [3:0] a_out;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [3:0] prev_pulse = 4'h0;

    pb_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pb_raw   (pb_raw),
        .a_raw    (a_raw),
        .pb_level (pb_level),
        .pb_pulse (pb_pulse),
        .a_out    (a_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pb, input logic [3:0] a);
        @(negedge clk);
        pb_raw = pb;
        a_raw  = a;
    endtask

    task automatic expectPulse(input int c, input logic [3:0] p, input logic [3:0] a);
        exp_t e;
        e.cyc   = c;
        e.pulse = p;
        e.a     = a;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'h0, a_raw);
    endtask

    // Monitor: every strobe the DUT presents is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pb_pulse != 4'h0) begin
                checkOutput("pulse_width", int'(pb_pulse & prev_pulse), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: got %0h expected none at cycle %0d", pb_pulse, cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pulse_cycle", cyc, e.cyc);
                    checkOutput("pulse_value", int'(pb_pulse), int'(e.pulse));
                    checkOutput("a_out_aligned", int'(a_out), int'(e.a));
                end
            end
            prev_pulse = pb_pulse;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_level", int'(pb_level), 0);
        checkOutput("reset_pulse", int'(pb_pulse), 0);
        checkOutput("reset_a_out", int'(a_out), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(DEB + 4);

        // Clean press on PB1 with a changing operand to check alignment.
        for (int i = 0; i < 12; i++) begin
            applyStimulus((i < 10) ? 4'h1 : 4'h0, 4'(i * 5 + 3));
            if (i == 0) begin
                c0 = cyc;
                expectPulse(c0 + 7, 4'h1, 4'hD);
            end
            if (i == 6) checkOutput("clean_level_before", int'(pb_level[0]), 0);
            if (i == 7) checkOutput("clean_level_after", int'(pb_level[0]), 1);
        end
        idle(10);

        // Bouncing press on PB2: 1,0,1,0 then held.
        for (int i = 0; i < 14; i++) begin
            applyStimulus((i < 4 && (i % 2) == 1) ? 4'h0 : 4'h2, 4'h5);
            if (i == 0) c0 = cyc;
            if (i == 4) expectPulse(c0 + 11, 4'h2, 4'h5);
            if (i == 10) checkOutput("bounce_level_before", int'(pb_level[1]), 0);
            if (i == 11) checkOutput("bounce_level_after", int'(pb_level[1]), 1);
        end
        idle(12);

        // PB3 held 20 cycles, then released with a two-cycle bounce.
        for (int i = 0; i < 31; i++) begin
            applyStimulus((i < 20 || i == 21) ? 4'h4 : 4'h0, 4'h9);
            if (i == 0) begin
                c0 = cyc;
                expectPulse(c0 + 7, 4'h4, 4'h9);
`ifdef PB_CONDITIONER_AUTOREPEAT_EN
                expectPulse(c0 + 15, 4'h4, 4'h9);
                expectPulse(c0 + 19, 4'h4, 4'h9);
`endif
            end
            if (i == 24) checkOutput("release_level_bounce", int'(pb_level[2]), 1);
            if (i == 28) checkOutput("release_level_before", int'(pb_level[2]), 1);
            if (i == 29) checkOutput("release_level_after", int'(pb_level[2]), 0);
        end
        idle(8);

        // All four buttons together with operand 4'hA.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'hF, 4'hA);
            if (i == 0) expectPulse(cyc + 7, 4'hF, 4'hA);
            if (i == 7) checkOutput("simul_level", int'(pb_level), 15);
        end
        idle(10);

        // PB4 held through an asynchronous reset pulse.
        for (int i = 0; i < 25; i++) begin
            applyStimulus(4'h8, 4'h3);
            if (i == 0) begin
                c0 = cyc;
                expectPulse(c0 + 7, 4'h8, 4'h3);
            end
            if (i == 11) begin
                checkOutput("hold_level_pre_reset", int'(pb_level), 8);
                rst_n = 1'b0;
                #1;
                checkOutput("midhold_reset_level", int'(pb_level), 0);
                checkOutput("midhold_reset_pulse", int'(pb_pulse), 0);
                checkOutput("midhold_reset_a_out", int'(a_out), 0);
            end
            if (i == 13) checkOutput("reset_held_level", int'(pb_level), 0);
            if (i == 14) begin
                rst_n = 1'b1;
                expectPulse(c0 + 21, 4'h8, 4'h3);
            end
            if (i == 20) checkOutput("post_reset_level_before", int'(pb_level), 0);
            if (i == 21) checkOutput("post_reset_level_after", int'(pb_level), 8);
        end
        idle(12);

        // PB1 held 30 cycles: one pulse, or the repeat train when enabled.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(4'h1, 4'h6);
            if (i == 0) begin
                c0 = cyc;
                expectPulse(c0 + 7, 4'h1, 4'h6);
`ifdef PB_CONDITIONER_AUTOREPEAT_EN
                expectPulse(c0 + 15, 4'h1, 4'h6);
                expectPulse(c0 + 19, 4'h1, 4'h6);
                expectPulse(c0 + 23, 4'h1, 4'h6);
                expectPulse(c0 + 27, 4'h1, 4'h6);
                expectPulse(c0 + 31, 4'h1, 4'h6);
`endif
            end
            if (i == 29) checkOutput("repeat_level", int'(pb_level[0]), 1);
        end
        idle(20);

        checkOutput("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
